// File: rtl/ula_defs_pkg.sv
// Definitions shared by the ULA operand-loading and result stages:
// FSM state encodings and the default operand width.
package ula_defs;

  localparam int LARGURA_PADRAO = 8;

  typedef enum logic [1:0] {
    ESTADO_ESPERA_A = 2'b00,
    ESTADO_ESPERA_B = 2'b01,
    ESTADO_PRONTO   = 2'b10
  } estado_t;

  // True in the states where the loader can take a word from the bus.
  function automatic logic aceita_dado(input estado_t estado);
    return (estado == ESTADO_ESPERA_A) || (estado == ESTADO_ESPERA_B);
  endfunction

endpackage

// File: rtl/registrador_carga.sv
// LARGURA-bit operand register: async active-low reset, synchronous clear
// (which takes priority) and synchronous load enable.
module registrador_carga
  import ula_defs::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               limpar,
  input  logic               carregar,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (limpar) begin
      q_reg <= '0;
    end else if (carregar) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/carregador_operandos_8bits.sv
// Operand loader ahead of the ULA logic units: captures A then B from a
// valid/ready bus, holds the pair until consumed, and counts consumed pairs.
module carregador_operandos_8bits
  import ula_defs::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] dado_in,
  input  logic               dado_valido,
  output logic               dado_pronto,
  input  logic               cancelar,
  output logic [LARGURA-1:0] a,
  output logic [LARGURA-1:0] b,
  output logic               operandos_validos,
  input  logic               consumido,
  output logic [7:0]         contador_ops
);

  estado_t    estado_reg;
  estado_t    estado_next;
  logic       validos_reg;
  logic [7:0] contador_reg;
  logic       transferencia;
  logic       carrega_a;
  logic       carrega_b;
  logic       conta_par;

  assign dado_pronto   = aceita_dado(estado_reg);
  assign transferencia = dado_valido && dado_pronto;
  assign carrega_a     = transferencia && (estado_reg == ESTADO_ESPERA_A);
  assign carrega_b     = transferencia && (estado_reg == ESTADO_ESPERA_B);
  assign conta_par     = (estado_reg == ESTADO_PRONTO) && consumido && !cancelar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg <= ESTADO_ESPERA_A;
    end else begin
      estado_reg <= estado_next;
    end
  end

  // The unused 2'b11 encoding falls through to the default and recovers.
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      ESTADO_ESPERA_A: if (transferencia) estado_next = ESTADO_ESPERA_B;
      ESTADO_ESPERA_B: if (transferencia) estado_next = ESTADO_PRONTO;
      ESTADO_PRONTO:   if (consumido)     estado_next = ESTADO_ESPERA_A;
      default:                            estado_next = ESTADO_ESPERA_A;
    endcase
    if (cancelar) begin
      estado_next = ESTADO_ESPERA_A;
    end
  end

  // Registered copy of (next state == PRONTO), so it always tracks the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validos_reg  <= 1'b0;
      contador_reg <= 8'd0;
    end else begin
      validos_reg <= (estado_next == ESTADO_PRONTO);
      if (conta_par) begin
        contador_reg <= contador_reg + 8'd1;
      end
    end
  end

  registrador_carga #(
    .LARGURA (LARGURA)
  ) u_reg_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .limpar   (cancelar),
    .carregar (carrega_a),
    .d        (dado_in),
    .q        (a)
  );

  registrador_carga #(
    .LARGURA (LARGURA)
  ) u_reg_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .limpar   (cancelar),
    .carregar (carrega_b),
    .d        (dado_in),
    .q        (b)
  );

  assign operandos_validos = validos_reg;
  assign contador_ops      = contador_reg;

endmodule

// File: tb/tb_carregador_operandos_8bits.sv
// Randomised self-checking bench for the operand loader against a
// queue-based reference model of collected words.
module tb_carregador_operandos_8bits;

  logic       clk;
  logic       rst_n;
  logic [7:0] dado_in;
  logic       dado_valido;
  logic       dado_pronto;
  logic       cancelar;
  logic [7:0] a;
  logic [7:0] b;
  logic       operandos_validos;
  logic       consumido;
  logic [7:0] contador_ops;

  int n_checks;
  int n_fail;

  // Reference model: words collected for the current pair, latched operands, pair count.
  bit [7:0] palavras[$];
  bit [7:0] m_a;
  bit [7:0] m_b;
  bit [7:0] m_cont;

  carregador_operandos_8bits #(.LARGURA(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dado_in           (dado_in),
    .dado_valido       (dado_valido),
    .dado_pronto       (dado_pronto),
    .cancelar          (cancelar),
    .a                 (a),
    .b                 (b),
    .operandos_validos (operandos_validos),
    .consumido         (consumido),
    .contador_ops      (contador_ops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    palavras.delete();
    m_a = 8'd0;
    m_b = 8'd0;
    m_cont = 8'd0;
  endtask

  task automatic model_step(input bit v, input bit [7:0] d, input bit canc, input bit cons);
    if (canc) begin
      palavras.delete();
      m_a = 8'd0;
      m_b = 8'd0;
    end else if (palavras.size() == 2) begin
      if (cons) begin
        m_cont = m_cont + 8'd1;
        palavras.delete();
      end
    end else if (v) begin
      palavras.push_back(d);
      if (palavras.size() == 1) m_a = d;
      else                      m_b = d;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, land 1 time unit after it.
  task automatic ciclo(input bit v, input bit [7:0] d, input bit canc, input bit cons);
    dado_valido = v;
    dado_in     = d;
    cancelar    = canc;
    consumido   = cons;
    @(posedge clk);
    model_step(v, d, canc, cons);
    #1;
    dado_valido = 1'b0;
    cancelar    = 1'b0;
    consumido   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dado_valido = 1'b0;
    dado_in = 8'd0;
    cancelar = 1'b0;
    consumido = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a !== 8'd0 || b !== 8'd0) begin
      n_fail++; $display("FAIL reset_ab: a=%h b=%h required 00 00", a, b);
    end
    n_checks++;
    if (operandos_validos !== 1'b0 || dado_pronto !== 1'b1) begin
      n_fail++; $display("FAIL reset_flags: validos=%b pronto=%b required 0 1", operandos_validos, dado_pronto);
    end
    n_checks++;
    if (contador_ops !== 8'd0) begin
      n_fail++; $display("FAIL reset_count: count=%0d required 0", contador_ops);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_or();
    ciclo(1'b1, 8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (operandos_validos !== 1'b0 || dado_pronto !== 1'b1 || a !== 8'hA5) begin
      n_fail++; $display("FAIL basic_first: a=%h validos=%b pronto=%b required a5 0 1", a, operandos_validos, dado_pronto);
    end
    ciclo(1'b1, 8'h5A, 1'b0, 1'b0);
    n_checks++;
    if (a !== 8'hA5 || b !== 8'h5A || operandos_validos !== 1'b1) begin
      n_fail++; $display("FAIL basic_pair: a=%h b=%h validos=%b required a5 5a 1", a, b, operandos_validos);
    end
    n_checks++;
    if ((a | b) !== 8'hFF) begin
      n_fail++; $display("FAIL basic_or: or=%h required ff", a | b);
    end
    $display("basic load: a=%h b=%h or=%h", a, b, a | b);
  endtask

  task automatic test_hold();
    bit [7:0] cont_antes;
    cont_antes = m_cont;
    for (int i = 0; i < 5; i++) begin
      ciclo(1'b1, 8'h33, 1'b0, 1'b0);
      n_checks++;
      if (a !== 8'hA5 || b !== 8'h5A || dado_pronto !== 1'b0 || operandos_validos !== 1'b1) begin
        n_fail++; $display("FAIL hold_%0d: a=%h b=%h pronto=%b validos=%b required a5 5a 0 1", i, a, b, dado_pronto, operandos_validos);
      end
    end
    ciclo(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (contador_ops !== cont_antes + 8'd1 || operandos_validos !== 1'b0 || dado_pronto !== 1'b1) begin
      n_fail++; $display("FAIL hold_consume: count=%0d validos=%b pronto=%b required %0d 0 1", contador_ops, operandos_validos, dado_pronto, cont_antes + 8'd1);
    end
    n_checks++;
    if (a !== 8'hA5 || b !== 8'h5A) begin
      n_fail++; $display("FAIL hold_keep: a=%h b=%h required a5 5a", a, b);
    end
    $display("hold/consume: count=%0d", contador_ops);
  endtask

  task automatic test_cancel();
    bit [7:0] cont_antes;
    cont_antes = m_cont;
    ciclo(1'b1, 8'h11, 1'b0, 1'b0);
    ciclo(1'b1, 8'h0F, 1'b1, 1'b0);
    n_checks++;
    if (a !== 8'h00 || b !== 8'h00 || operandos_validos !== 1'b0 || dado_pronto !== 1'b1) begin
      n_fail++; $display("FAIL cancel_clear: a=%h b=%h validos=%b pronto=%b required 00 00 0 1", a, b, operandos_validos, dado_pronto);
    end
    n_checks++;
    if (contador_ops !== cont_antes) begin
      n_fail++; $display("FAIL cancel_count: count=%0d required %0d", contador_ops, cont_antes);
    end
    // Back in ESPERA_A: the next word must land in a, not b.
    ciclo(1'b1, 8'h77, 1'b0, 1'b0);
    n_checks++;
    if (a !== 8'h77 || b !== 8'h00 || operandos_validos !== 1'b0) begin
      n_fail++; $display("FAIL cancel_state: a=%h b=%h validos=%b required 77 00 0", a, b, operandos_validos);
    end
    // Cancel while the pair is held, with a simultaneous consume.
    ciclo(1'b1, 8'h88, 1'b0, 1'b0);
    ciclo(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (a !== 8'h00 || b !== 8'h00 || contador_ops !== cont_antes || dado_pronto !== 1'b1) begin
      n_fail++; $display("FAIL cancel_pronto: a=%h b=%h count=%0d pronto=%b required 00 00 %0d 1", a, b, contador_ops, dado_pronto, cont_antes);
    end
    $display("cancel: a=%h b=%h count=%0d", a, b, contador_ops);
  endtask

  task automatic test_ignored_ack();
    bit [7:0] cont_antes;
    cont_antes = m_cont;
    ciclo(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (contador_ops !== cont_antes || dado_pronto !== 1'b1 || operandos_validos !== 1'b0) begin
      n_fail++; $display("FAIL ack_ignored: count=%0d pronto=%b validos=%b required %0d 1 0", contador_ops, dado_pronto, operandos_validos, cont_antes);
    end
    ciclo(1'b1, 8'hC3, 1'b0, 1'b0);
    n_checks++;
    if (a !== 8'hC3 || operandos_validos !== 1'b0) begin
      n_fail++; $display("FAIL ack_state: a=%h validos=%b required c3 0", a, operandos_validos);
    end
    ciclo(1'b1, 8'h3C, 1'b0, 1'b0);
    ciclo(1'b0, 8'h00, 1'b0, 1'b1);
    $display("ignored ack: count=%0d", contador_ops);
  endtask

  task automatic test_random();
    int erros_antes;
    erros_antes = n_fail;
    for (int i = 0; i < 400; i++) begin
      ciclo($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
      n_checks++;
      if (a !== m_a || b !== m_b || operandos_validos !== (palavras.size() == 2) ||
          dado_pronto !== (palavras.size() < 2) || contador_ops !== m_cont) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h v=%b p=%b c=%0d required %h %h %b %b %0d", i, a, b,
                 operandos_validos, dado_pronto, contador_ops, m_a, m_b, palavras.size() == 2,
                 palavras.size() < 2, m_cont);
      end
    end
    $display("random: 400 cycles, new errors=%0d", n_fail - erros_antes);
  endtask

  task automatic test_back_to_back();
    bit [7:0] x;
    bit [7:0] y;
    if (palavras.size() == 2) ciclo(1'b0, 8'h00, 1'b0, 1'b1);
    ciclo(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      ciclo(1'b1, x, 1'b0, 1'b0);
      ciclo(1'b1, y, 1'b0, 1'b0);
      n_checks++;
      if (a !== x || b !== y || operandos_validos !== 1'b1) begin
        n_fail++; $display("FAIL b2b_%0d: a=%h b=%h validos=%b required %h %h 1", k, a, b, operandos_validos, x, y);
      end
      ciclo(1'b1, 8'hEE, 1'b0, 1'b1);
      $display("b2b pair %0d: a=%h b=%h count=%0d", k, a, b, contador_ops);
    end
  endtask

  task automatic test_wrap();
    // Fresh reset so the count starts from zero.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 1; p <= 256; p++) begin
      ciclo(1'b1, 8'(p), 1'b0, 1'b0);
      ciclo(1'b1, 8'(~p), 1'b0, 1'b0);
      ciclo(1'b0, 8'h00, 1'b0, 1'b1);
      if (p == 255) begin
        n_checks++;
        if (contador_ops !== 8'd255) begin
          n_fail++; $display("FAIL wrap_255: count=%0d required 255", contador_ops);
        end
        $display("wrap: after pair 255 count=%0d", contador_ops);
      end
    end
    n_checks++;
    if (contador_ops !== 8'd0) begin
      n_fail++; $display("FAIL wrap_0: count=%0d required 0", contador_ops);
    end
    $display("wrap: after pair 256 count=%0d", contador_ops);
  endtask

  task automatic test_async_reset();
    // Reset asserted mid-cycle while waiting for B must act without an edge.
    ciclo(1'b1, 8'h9C, 1'b0, 1'b0);
    ciclo(1'b1, 8'h4B, 1'b0, 1'b0);
    ciclo(1'b0, 8'h00, 1'b0, 1'b1);
    ciclo(1'b1, 8'hD2, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (a !== 8'h00 || b !== 8'h00 || contador_ops !== 8'd0 ||
        operandos_validos !== 1'b0 || dado_pronto !== 1'b1) begin
      n_fail++; $display("FAIL async_b: a=%h b=%h count=%0d validos=%b pronto=%b required 00 00 0 0 1", a, b, contador_ops, operandos_validos, dado_pronto);
    end
    #2;
    rst_n = 1'b1;
    // First edge after release accepts a word.
    ciclo(1'b1, 8'h61, 1'b0, 1'b0);
    n_checks++;
    if (a !== 8'h61 || dado_pronto !== 1'b1) begin
      n_fail++; $display("FAIL release_first: a=%h pronto=%b required 61 1", a, dado_pronto);
    end
    ciclo(1'b1, 8'h16, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (a !== 8'h00 || b !== 8'h00 || operandos_validos !== 1'b0 || dado_pronto !== 1'b1) begin
      n_fail++; $display("FAIL async_pronto: a=%h b=%h validos=%b pronto=%b required 00 00 0 1", a, b, operandos_validos, dado_pronto);
    end
    #2;
    rst_n = 1'b1;
    $display("async reset: a=%h b=%h pronto=%b", a, b, dado_pronto);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic_or();
    test_hold();
    test_cancel();
    test_ignored_ack();
    test_random();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

endmodule
